// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared types and constants for the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int c_TIMEOUT_CYCLES = 16;

    typedef struct packed {
        logic mem2reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam wb_ctrl_t c_WB_BUBBLE = '{mem2reg: 1'b0, reg_write: 1'b0};

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
//  Module      : mem_stage_if
//  Description : Ready/valid data-memory port between MEM stage and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : IDLE/WAIT access controller with timeout and sticky errors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       mem_read,
    input  wire logic       mem_write,
    input  wire logic [1:0] addr_lo,
    input  wire logic       dmem_ready,
    output logic            dmem_req,
    output logic            stall,
    output logic            complete,
    output logic            abort,
    output logic            misalign_err,
    output logic            bus_err
);

    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TIMER_MAX = c_TW'(TIMEOUT_CYCLES);

    mem_state_t      r_state;
    mem_state_t      w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic            w_req;
    logic            w_abort;
    logic            w_access;
    logic            w_misaligned;
    logic            w_aligned;

    assign w_access     = mem_read | mem_write;
    assign w_misaligned = w_access & (addr_lo != 2'b00);
    assign w_aligned    = w_access & ~w_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_req       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned) begin
                    w_req = 1'b1;
                    if (!dmem_ready) begin
                        w_state_nxt = WAIT;
                        w_timer_nxt = c_TW'(1);
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                // A late ready wins over the timeout on the same cycle.
                if (dmem_ready) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_TIMER_MAX) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Request must fall with rst_n even though EX/MEM may still hold an access.
    assign dmem_req = w_req & rst_n;
    assign complete = dmem_req & dmem_ready;
    assign abort    = w_abort;
    assign stall    = w_aligned & ~dmem_ready & ~w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            if (w_misaligned) misalign_err <= 1'b1;
            if (w_abort)      bus_err      <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage: branch resolve, dmem port, MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] PC_EXMEM,
    input  wire logic [31:0] read_Address_EXMEM,
    input  wire logic [31:0] write_Data_EXMEM,
    input  wire logic [4:0]  rd_EXMEM,
    input  wire logic        branch_EXMEM,
    input  wire logic        zero_EXMEM,
    input  wire logic        memRead_EXMEM,
    input  wire logic        memWrite_EXMEM,
    input  wire logic        mem2reg_EXMEM,
    input  wire logic        RegWrite_EXMEM,
    mem_stage_if.master      dmem,
    output logic             PCSrc,
    output logic [31:0]      branch_target,
    output logic             flush,
    output logic             stall_MEM,
    output logic [31:0]      read_data_MEMWB,
    output logic [31:0]      alu_result_MEMWB,
    output logic [4:0]       rd_MEMWB,
    output logic             mem2reg_MEMWB,
    output logic             RegWrite_MEMWB,
    output logic             misalign_err,
    output logic             bus_err
);

    logic        w_req;
    logic        w_complete;
    logic        w_abort;
    logic        w_misaligned;
    logic        w_retire_bubble;
    logic [31:0] r_read_data;
    logic [31:0] r_alu_result;
    logic [4:0]  r_rd;
    wb_ctrl_t    r_wb_ctrl;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (memRead_EXMEM),
        .mem_write    (memWrite_EXMEM),
        .addr_lo      (read_Address_EXMEM[1:0]),
        .dmem_ready   (dmem.dmem_ready),
        .dmem_req     (w_req),
        .stall        (stall_MEM),
        .complete     (w_complete),
        .abort        (w_abort),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & memWrite_EXMEM;
    assign dmem.dmem_addr  = read_Address_EXMEM;
    assign dmem.dmem_wdata = write_Data_EXMEM;

    assign PCSrc         = branch_EXMEM & zero_EXMEM;
    assign flush         = PCSrc;
    assign branch_target = PC_EXMEM;

    assign w_misaligned    = (memRead_EXMEM | memWrite_EXMEM) & (read_Address_EXMEM[1:0] != 2'b00);
    assign w_retire_bubble = w_misaligned | w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_wb_ctrl    <= c_WB_BUBBLE;
        end else if (stall_MEM) begin
            r_wb_ctrl <= c_WB_BUBBLE;
        end else begin
            if (w_complete && memRead_EXMEM) r_read_data <= dmem.dmem_rdata;
            r_alu_result <= read_Address_EXMEM;
            r_rd         <= rd_EXMEM;
            if (w_retire_bubble) r_wb_ctrl <= c_WB_BUBBLE;
            else                 r_wb_ctrl <= '{mem2reg: mem2reg_EXMEM, reg_write: RegWrite_EXMEM};
        end
    end

    assign read_data_MEMWB  = r_read_data;
    assign alu_result_MEMWB = r_alu_result;
    assign rd_MEMWB         = r_rd;
    assign mem2reg_MEMWB    = r_wb_ctrl.mem2reg;
    assign RegWrite_MEMWB   = r_wb_ctrl.reg_write;

endmodule

`default_nettype wire
